// File: rtl/free_list.sv
// Purpose : physical-register free list; circular FIFO of register indices fed by
//           ROB commit (up to 4 releases/cycle), drained by rename (up to 4 allocs/cycle).
// Latency : allocation outputs are combinational from current state; released
//           registers become allocatable the cycle after they are pushed.
// Backpressure: all-or-nothing; o_grant=0 when the request exceeds the held count,
//           nothing is consumed and rename must re-present the request.
// Ports   : i_clk/i_rst         clock, synchronous active-high reset
//           i_com_prd4x/i_com_en released registers and per-lane valids from commit
//           i_req               per-lane allocation request from rename
//           o_prd4x/o_grant     lane-aligned allocated registers, request fully served
//           o_count/o_err       free entries held, sticky overflow/underflow/reg0 error
module free_list #(
  parameter int WIDTH_REG = 7,
  parameter int NARCH     = 32,
  parameter int NLANE     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [4*WIDTH_REG-1:0]   i_com_prd4x,
  input  logic [3:0]               i_com_en,
  input  logic [3:0]               i_req,
  output logic [4*WIDTH_REG-1:0]   o_prd4x,
  output logic                     o_grant,
  output logic [WIDTH_REG:0]       o_count,
  output logic                     o_err
);

  localparam int NPREG = 1 << WIDTH_REG;

  typedef logic [WIDTH_REG-1:0] preg_t;

  preg_t              mem_q [NPREG];
  preg_t              head_q, head_d;
  preg_t              tail_q, tail_d;
  logic [WIDTH_REG:0] count_q, count_d;
  logic               err_q, err_d;

  logic [2:0]         npop, npush, npopped;
  preg_t              rd_idx   [4];
  preg_t              push_idx [4];
  logic               bad_push;
  // One extra bit beyond count so overflow past NPREG-1 is visible before truncation.
  logic [WIDTH_REG+1:0] sum;

  always_comb begin
    npop     = '0;
    npush    = '0;
    bad_push = 1'b0;
    o_prd4x  = '0;
    for (int k = 0; k < 4; k++) begin
      // Offsets are the number of active lanes below k, giving lane-order compaction;
      // the 7-bit pointer add wraps modulo SIZE for free.
      rd_idx[k]   = head_q + preg_t'(npop);
      push_idx[k] = tail_q + preg_t'(npush);
      npop        = npop  + {2'b00, i_req[k]};
      npush       = npush + {2'b00, i_com_en[k]};
      if (i_req[k]) begin
        o_prd4x[k*WIDTH_REG +: WIDTH_REG] = mem_q[rd_idx[k]];
      end
      if (i_com_en[k] && (i_com_prd4x[k*WIDTH_REG +: WIDTH_REG] == '0)) begin
        bad_push = 1'b1;
      end
    end
    // Grant is judged on the pre-push count: no same-cycle bypass from commit.
    o_grant = ((WIDTH_REG+1)'(npop) <= count_q);
    npopped = o_grant ? npop : 3'd0;
    sum     = {1'b0, count_q} + (WIDTH_REG+2)'(npush) - (WIDTH_REG+2)'(npopped);
    count_d = sum[WIDTH_REG:0];
    head_d  = head_q + preg_t'(npopped);
    tail_d  = tail_q + preg_t'(npush);
    // Reg 0 is never free, so at most NPREG-1 entries may legally be held.
    err_d   = err_q | bad_push | (sum > (WIDTH_REG+2)'(NPREG-1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NPREG; i++) begin
        mem_q[i] <= (i < NPREG-NARCH) ? preg_t'(NARCH+i) : '0;
      end
      head_q  <= '0;
      tail_q  <= preg_t'(NPREG-NARCH);
      count_q <= (WIDTH_REG+1)'(NPREG-NARCH);
      err_q   <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (i_com_en[k]) begin
          mem_q[push_idx[k]] <= i_com_prd4x[k*WIDTH_REG +: WIDTH_REG];
        end
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign o_count = count_q;
  assign o_err   = err_q;

endmodule
